// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, syncs, data enable and a one-cycle pixel fetch.
// Define VTG_TEST_PATTERN_EN to ignore pixel_i and drive a built-in x/y test pattern instead.
`timescale 1ns/1ps
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CNT_W    = 12
) (
    input  logic             pixclk,
    input  logic             rst,
    output logic             req_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    input  logic [23:0]      pixel_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [7:0]       red_o,
    output logic [7:0]       green_o,
    output logic [7:0]       blue_o,
    output logic             frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             active;
    logic             in_hs;
    logic             in_vs;
    logic             at_origin;

    // Stage-1 flags; the syncs are already encoded at their output polarity.
    logic             hs1;
    logic             vs1;
    logic             de1;
    logic             fs1;
    logic [23:0]      pix_next;

    always_comb begin
        h_wrap    = (h_cnt == H_LAST);
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_hs     = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        in_vs     = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            req_o <= 1'b0;
            x_o   <= '0;
            y_o   <= '0;
            de1   <= 1'b0;
            fs1   <= 1'b0;
            hs1   <= ~HS_ON;
            vs1   <= ~VS_ON;
        end else begin
            req_o <= active;
            x_o   <= h_cnt;
            y_o   <= v_cnt;
            de1   <= active;
            fs1   <= at_origin;
            hs1   <= in_hs ? HS_ON : ~HS_ON;
            vs1   <= in_vs ? VS_ON : ~VS_ON;
        end
    end

`ifdef VTG_TEST_PATTERN_EN
    logic unused_pixel;
    assign unused_pixel = ^pixel_i;
    assign pix_next     = {x_o[7:0], y_o[7:0], {8{x_o[5] ^ y_o[5]}}};
`else
    assign pix_next = pixel_i;
`endif

    // The source answers req_o within the same cycle, so pixel_i lines up with the stage-1 flags.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            hsync_o       <= ~HS_ON;
            vsync_o       <= ~VS_ON;
            de_o          <= 1'b0;
            frame_start_o <= 1'b0;
            red_o         <= 8'h00;
            green_o       <= 8'h00;
            blue_o        <= 8'h00;
        end else begin
            hsync_o       <= hs1;
            vsync_o       <= vs1;
            de_o          <= de1;
            frame_start_o <= fs1;
            if (de1) begin
                {red_o, green_o, blue_o} <= pix_next;
            end else begin
                {red_o, green_o, blue_o} <= 24'h000000;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on an 8x6 raster (H 4/1/2/1, V 3/1/1/1), both sync polarities.
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int CW = 12;

    logic          pixclk = 1'b0;
    logic          rst = 1'b1;
    logic [23:0]   pixel_i = 24'h000000;

    logic          req, hsync, vsync, de, fs;
    logic [CW-1:0] x, y;
    logic [7:0]    red, green, blue;

    logic          n_req, n_hsync, n_vsync, n_de, n_fs;
    logic [CW-1:0] n_x, n_y;
    logic [7:0]    n_red, n_green, n_blue;

    int checks = 0;
    int errors = 0;

    always #5 pixclk = ~pixclk;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CNT_W(CW)
    ) dut (
        .pixclk(pixclk), .rst(rst), .req_o(req), .x_o(x), .y_o(y), .pixel_i(pixel_i),
        .hsync_o(hsync), .vsync_o(vsync), .de_o(de),
        .red_o(red), .green_o(green), .blue_o(blue), .frame_start_o(fs)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CNT_W(CW)
    ) dut_n (
        .pixclk(pixclk), .rst(rst), .req_o(n_req), .x_o(n_x), .y_o(n_y), .pixel_i(pixel_i),
        .hsync_o(n_hsync), .vsync_o(n_vsync), .de_o(n_de),
        .red_o(n_red), .green_o(n_green), .blue_o(n_blue), .frame_start_o(n_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, let the source answer the new request, then sample on the falling edge.
    task automatic tick();
        @(posedge pixclk);
        #1;
`ifdef VTG_TEST_PATTERN_EN
        pixel_i = 24'hFFFFFF;
`else
        pixel_i = {x[7:0], y[7:0], 8'hA5};
`endif
        @(negedge pixclk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, req, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_fs"}, fs, 0);
        check({tag, "_rgb"}, {red, green, blue}, 0);
        check({tag, "_hsync"}, hsync, 0);
        check({tag, "_vsync"}, vsync, 0);
        check({tag, "_n_hsync"}, n_hsync, 1);
        check({tag, "_n_vsync"}, n_vsync, 1);
    endtask

    // n = number of rising edges since reset release.
    task automatic check_cycle(input int n);
        int  p1, h1, v1, p2, h2, v2;
        logic de_e, hs_e, vs_e, fs_e;
        logic [7:0] r_e, g_e, b_e;
        p1 = n - 1;
        h1 = p1 % 8;
        v1 = (p1 / 8) % 6;
        check("req", req, (h1 < 4) && (v1 < 3));
        check("x", x, h1);
        check("y", y, v1);
        de_e = 1'b0; hs_e = 1'b0; vs_e = 1'b0; fs_e = 1'b0;
        r_e = 8'h00; g_e = 8'h00; b_e = 8'h00;
        if (n >= 2) begin
            p2   = n - 2;
            h2   = p2 % 8;
            v2   = (p2 / 8) % 6;
            de_e = (h2 < 4) && (v2 < 3);
            hs_e = (h2 >= 5) && (h2 < 7);
            vs_e = (v2 == 4);
            fs_e = (p2 % 48 == 0);
            if (de_e) begin
                r_e = 8'(h2);
                g_e = 8'(v2);
`ifdef VTG_TEST_PATTERN_EN
                b_e = 8'h00;
`else
                b_e = 8'hA5;
`endif
            end
        end
        check("de", de, de_e);
        check("hsync", hsync, hs_e);
        check("vsync", vsync, vs_e);
        check("frame_start", fs, fs_e);
        check("red", red, r_e);
        check("green", green, g_e);
        check("blue", blue, b_e);
        check("n_hsync", n_hsync, !hs_e);
        check("n_vsync", n_vsync, !vs_e);
        check("n_de", n_de, de_e);
    endtask

    initial begin
        int   fs_first = -1;
        int   fs_second = -1;
        int   de_rise = -1;
        int   hs_rise = -1;
        int   de_cnt = 0;
        int   hs_cnt = 0;
        int   vs_cnt = 0;
        logic de_prev = 1'b0;
        logic hs_prev = 1'b0;

        repeat (3) @(negedge pixclk);
        check_reset("reset");
        rst = 1'b0;

        for (int n = 1; n <= 115; n++) begin
            tick();
            check_cycle(n);
            if (n == 2) begin
                check("fs_after_2_edges", fs, 1);
                check("de_after_2_edges", de, 1);
            end
            if (n == 13) begin
                check("pix31_red", red, 3);
                check("pix31_green", green, 1);
`ifdef VTG_TEST_PATTERN_EN
                check("pix31_blue", blue, 0);
`else
                check("pix31_blue", blue, 8'hA5);
`endif
            end
            if (n >= 2 && n <= 49) begin
                de_cnt += int'(de);
                hs_cnt += int'(hsync);
                vs_cnt += int'(vsync);
            end
            if (fs && fs_first < 0) fs_first = n;
            else if (fs && fs_second < 0) fs_second = n;
            if (de && !de_prev && de_rise < 0) de_rise = n;
            if (hsync && !hs_prev && hs_rise < 0 && de_rise >= 0) hs_rise = n;
            de_prev = de;
            hs_prev = hsync;
        end

        check("de_cycles_per_frame", de_cnt, 12);
        check("hsync_cycles_per_frame", hs_cnt, 12);
        check("vsync_cycles_per_frame", vs_cnt, 8);
        check("frame_start_period", fs_second - fs_first, 48);
        check("hsync_after_de", hs_rise - de_rise, 5);

        // Counter now sits at h=3, v=2 with de and req both high.
        check("pre_reset_de", de, 1);
        check("pre_reset_req", req, 1);
        #2 rst = 1'b1;
        #0.5 check_reset("midline_reset");
        #0.5 rst = 1'b0;

        for (int n = 1; n <= 10; n++) begin
            tick();
            check_cycle(n);
        end
        check("fs_after_restart", fs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
